operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port req_valid, input, 1 bit: issue stage offers an instruction.
REQ-004 SHALL have port req_ready, output, 1 bit: block accepts the offered instruction this cycle.
REQ-005 SHALL have ports req_src_a and req_src_b, inputs, IR::reg_t: source register numbers.
REQ-006 SHALL have port req_dest, input, IR::reg_t: destination register number.
REQ-007 SHALL have port req_wr, input, 1 bit: instruction writes req_dest.
REQ-008 SHALL have ports rf_src_a and rf_src_b, outputs, IR::reg_t: register file read addresses.
REQ-009 SHALL have ports rf_reg_a and rf_reg_b, inputs, Global::size_t: register file read data; combinational; x0 reads 0.
REQ-010 SHALL have ports wb_load (1 bit), wb_dest (IR::reg_t) and wb_data (Global::size_t), inputs: writeback, same signals that drive the register file write port.
REQ-011 SHALL have port op_valid, output, 1 bit: operand bundle valid to execute.
REQ-012 SHALL have port op_ready, input, 1 bit: execute consumes the bundle.
REQ-013 SHALL have ports op_a and op_b, outputs, Global::size_t: resolved operands.
REQ-014 SHALL have ports op_dest (IR::reg_t) and op_wr (1 bit), outputs: forwarded destination and write flag.

Function
REQ-015 SHALL drive rf_src_a = req_src_a and rf_src_b = req_src_b combinationally.
REQ-016 SHALL keep a pending bit per register 1..31; register 0 is never pending.
REQ-017 SHALL flag a RAW hazard when a nonzero source has its pending bit set, unless wb_load=1 and wb_dest equals that source in the same cycle.
REQ-018 SHALL flag a WAW hazard when req_wr=1, req_dest!=0 and pending[req_dest]=1.
REQ-019 SHALL drive req_ready = !rst && !hazard && (!op_valid || op_ready).
REQ-020 SHALL bypass writeback data: if wb_load=1, wb_dest!=0 and wb_dest equals the source, use wb_data as that operand; otherwise use rf_reg_a or rf_reg_b.
REQ-021 SHALL, on accept (req_valid && req_ready), register op_a, op_b, op_dest and op_wr and set op_valid=1 on the next edge; latency is exactly 1 cycle.
REQ-022 SHALL hold op_* stable while op_valid=1 and op_ready=0.
REQ-023 SHALL clear op_valid on an edge where op_valid && op_ready holds and no new accept occurs; it SHALL sustain 1 accept per cycle.
REQ-024 SHALL set pending[req_dest] on accept when req_wr=1 and req_dest!=0.
REQ-025 SHALL clear pending[wb_dest] when wb_load=1 and wb_dest!=0.
REQ-026 SHALL give set priority when a set and a clear target the same register in the same cycle.
REQ-027 SHALL treat a writeback to a non-pending register as a no-op, with no error.
REQ-028 SHALL have req_ready independent of req_valid, so there is no combinational loop to the issue stage.

Reset
REQ-029 SHALL, while rst=1, clear all pending bits and drive op_valid=0, op_a=0, op_b=0, op_dest=0, op_wr=0 and req_ready=0.
REQ-030 SHALL discard any bundle in flight when reset is asserted mid-operation; no accept occurs in a reset cycle.

Structure
REQ-031 SHALL use the existing Global::size_t and IR::reg_t types; the register count constant NREGS=32 SHALL live in package IR.
REQ-032 SHALL place the pending vector with its set/clear logic and hazard lookup in one sub-module, reg_scoreboard; bypass muxes and the output register stay in operand_fetch.

Verification
REQ-033 SHALL cover: reset, then issue src_a=1, src_b=2 with rf data 5 and 7 -> op_valid=1 one cycle later with op_a=5 and op_b=7.
REQ-034 SHALL cover: issue dest=3 with req_wr=1, then next cycle src_a=3 with no writeback -> req_ready=0 until wb_load=1 and wb_dest=3 with wb_data=0x2A; in that cycle req_ready=1 and op_a=0x2A on the following cycle.
REQ-035 SHALL cover: issue writing x0, then read src_a=0 -> no stall, op_a=0, pending stays all zero.
REQ-036 SHALL cover: op_ready=0 held 3 cycles with a second request waiting -> op_* unchanged, req_ready=0; op_ready=1 -> second bundle appears the next cycle.
REQ-037 SHALL cover: WAW case, dest=4 pending and a new request with req_dest=4 and req_wr=1 -> stall until writeback of x4.
REQ-038 SHALL cover: rst asserted with op_valid=1 and pending[5]=1 -> next cycle op_valid=0 and src_a=5 issues without stall.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// rtl/operand_fetch_pkg.sv - shared data-word and register-number types for the operand fetch slice
package Global;
    localparam int XLEN = 32;
    typedef logic [XLEN-1:0] size_t;
endpackage

package IR;
    localparam int NREGS = 32;
    localparam int REG_W = $clog2(NREGS);
    typedef logic [REG_W-1:0] reg_t;
endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending bits with RAW/WAW hazard lookup
module reg_scoreboard
    import IR::*;
(
    input  logic clk,
    input  logic rst,
    input  reg_t src_a,
    input  reg_t src_b,
    input  reg_t dest,
    input  logic wr,
    input  logic accept,
    input  logic wb_load,
    input  reg_t wb_dest,
    output logic hazard
);

    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_next;
    logic             raw_a;
    logic             raw_b;
    logic             waw;

    // A writeback landing this cycle resolves a RAW stall immediately via the bypass path.
    always_comb begin
        raw_a  = (src_a != '0) && pending[src_a] && !(wb_load && (wb_dest == src_a));
        raw_b  = (src_b != '0) && pending[src_b] && !(wb_load && (wb_dest == src_b));
        waw    = wr && (dest != '0) && pending[dest];
        hazard = raw_a || raw_b || waw;
    end

    // Set is applied after clear so a same-register collision leaves the bit set.
    always_comb begin
        pending_next = pending;
        if (wb_load && (wb_dest != '0)) begin
            pending_next[wb_dest] = 1'b0;
        end
        if (accept && wr && (dest != '0)) begin
            pending_next[dest] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - resolves source operands with writeback bypass and hands them to execute
module operand_fetch
    import Global::*;
    import IR::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  req_valid,
    output logic  req_ready,
    input  reg_t  req_src_a,
    input  reg_t  req_src_b,
    input  reg_t  req_dest,
    input  logic  req_wr,
    output reg_t  rf_src_a,
    output reg_t  rf_src_b,
    input  size_t rf_reg_a,
    input  size_t rf_reg_b,
    input  logic  wb_load,
    input  reg_t  wb_dest,
    input  size_t wb_data,
    output logic  op_valid,
    input  logic  op_ready,
    output size_t op_a,
    output size_t op_b,
    output reg_t  op_dest,
    output logic  op_wr
);

    logic  hazard;
    logic  accept;
    size_t fwd_a;
    size_t fwd_b;

    assign rf_src_a = req_src_a;
    assign rf_src_b = req_src_b;

    reg_scoreboard u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .src_a   (req_src_a),
        .src_b   (req_src_b),
        .dest    (req_dest),
        .wr      (req_wr),
        .accept  (accept),
        .wb_load (wb_load),
        .wb_dest (wb_dest),
        .hazard  (hazard)
    );

    // Ready never looks at req_valid, keeping the handshake free of loops.
    assign req_ready = !rst && !hazard && (!op_valid || op_ready);
    assign accept    = req_valid && req_ready;

    always_comb begin
        fwd_a = rf_reg_a;
        fwd_b = rf_reg_b;
        if (wb_load && (wb_dest != '0) && (wb_dest == req_src_a)) begin
            fwd_a = wb_data;
        end
        if (wb_load && (wb_dest != '0) && (wb_dest == req_src_b)) begin
            fwd_b = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            op_dest  <= '0;
            op_wr    <= 1'b0;
        end else if (accept) begin
            op_valid <= 1'b1;
            op_a     <= fwd_a;
            op_b     <= fwd_b;
            op_dest  <= req_dest;
            op_wr    <= req_wr;
        end else if (op_ready) begin
            op_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - scoreboard bench for operand_fetch with directed and random traffic
module tb_operand_fetch;
    import Global::*;
    import IR::*;

    typedef struct {
        size_t a;
        size_t b;
        reg_t  d;
        logic  w;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst;
    logic  req_valid;
    logic  req_ready;
    reg_t  req_src_a;
    reg_t  req_src_b;
    reg_t  req_dest;
    logic  req_wr;
    reg_t  rf_src_a;
    reg_t  rf_src_b;
    size_t rf_reg_a;
    size_t rf_reg_b;
    logic  wb_load;
    reg_t  wb_dest;
    size_t wb_data;
    logic  op_valid;
    logic  op_ready;
    size_t op_a;
    size_t op_b;
    reg_t  op_dest;
    logic  op_wr;

    size_t rf [NREGS];
    logic  rst_q = 1'b0;

    logic [NREGS-1:0] m_pend = '0;
    logic             m_valid = 1'b0;
    exp_t             expq [$];

    int checks = 0;
    int failures = 0;

    operand_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_src_a (req_src_a),
        .req_src_b (req_src_b),
        .req_dest  (req_dest),
        .req_wr    (req_wr),
        .rf_src_a  (rf_src_a),
        .rf_src_b  (rf_src_b),
        .rf_reg_a  (rf_reg_a),
        .rf_reg_b  (rf_reg_b),
        .wb_load   (wb_load),
        .wb_dest   (wb_dest),
        .wb_data   (wb_data),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_dest   (op_dest),
        .op_wr     (op_wr)
    );

    always #5 clk = ~clk;

    // Register file behaviour: combinational read, x0 reads zero, write on the edge.
    assign rf_reg_a = (rf_src_a == 5'd0) ? 32'd0 : rf[rf_src_a];
    assign rf_reg_b = (rf_src_b == 5'd0) ? 32'd0 : rf[rf_src_b];

    always @(posedge clk) begin
        rst_q <= rst;
        if (wb_load && wb_dest != 5'd0) rf[wb_dest] <= wb_data;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic size_t operand(input reg_t s);
        if (wb_load && wb_dest != 5'd0 && wb_dest == s) return wb_data;
        if (s == 5'd0) return 32'd0;
        return rf[s];
    endfunction

    function automatic logic raw(input reg_t s);
        return (s != 5'd0) && m_pend[s] && !(wb_load && wb_dest == s);
    endfunction

    // Reference model: decides readiness and records every accepted bundle.
    initial begin
        forever begin
            logic haz, rdy, acc;
            exp_t e;
            @(negedge clk);
            #1;
            haz = raw(req_src_a) || raw(req_src_b) ||
                  (req_wr && req_dest != 5'd0 && m_pend[req_dest]);
            rdy = !rst && !haz && (!m_valid || op_ready);
            check("req_ready", {31'd0, req_ready}, {31'd0, rdy});
            if (rst) begin
                m_pend  = '0;
                m_valid = 1'b0;
                expq.delete();
            end else begin
                acc = req_valid && rdy;
                if (acc) begin
                    e.a = operand(req_src_a);
                    e.b = operand(req_src_b);
                    e.d = req_dest;
                    e.w = req_wr;
                    expq.push_back(e);
                end
                if (wb_load && wb_dest != 5'd0) m_pend[wb_dest] = 1'b0;
                if (acc && req_wr && req_dest != 5'd0) m_pend[req_dest] = 1'b1;
                m_valid = acc ? 1'b1 : (op_ready ? 1'b0 : m_valid);
            end
        end
    end

    // Monitor: compares whatever execute sees against the oldest expected bundle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_q) begin
                check("rst_op_valid", {31'd0, op_valid}, 32'd0);
                check("rst_op_a", op_a, 32'd0);
                check("rst_op_b", op_b, 32'd0);
                check("rst_op_dest", {27'd0, op_dest}, 32'd0);
                check("rst_op_wr", {31'd0, op_wr}, 32'd0);
            end else begin
                check("op_valid", {31'd0, op_valid}, {31'd0, expq.size() != 0});
                if (op_valid && expq.size() != 0) begin
                    check("op_a", op_a, expq[0].a);
                    check("op_b", op_b, expq[0].b);
                    check("op_dest", {27'd0, op_dest}, {27'd0, expq[0].d});
                    check("op_wr", {31'd0, op_wr}, {31'd0, expq[0].w});
                    if (op_ready) void'(expq.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic req(input logic v, input reg_t a, input reg_t b, input reg_t d, input logic w);
        req_valid = v;
        req_src_a = a;
        req_src_b = b;
        req_dest  = d;
        req_wr    = w;
    endtask

    task automatic wb(input logic l, input reg_t d, input size_t data);
        wb_load = l;
        wb_dest = d;
        wb_data = data;
    endtask

    initial begin
        rst = 1'b1;
        op_ready = 1'b1;
        req(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        wb(1'b0, 5'd0, 32'd0);
        #1;
        for (int i = 1; i < NREGS; i++) begin
            wb(1'b1, 5'(i), (i == 1) ? 32'd5 : (i == 2) ? 32'd7 : 32'(i * 32'h1111));
            tick();
        end
        wb(1'b0, 5'd0, 32'd0);
        tick(2);
        rst = 1'b0;

        req(1'b1, 5'd1, 5'd2, 5'd0, 1'b0);
        tick();
        req(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick(2);

        req(1'b1, 5'd0, 5'd0, 5'd3, 1'b1);
        tick();
        req(1'b1, 5'd3, 5'd0, 5'd0, 1'b0);
        tick(3);
        wb(1'b1, 5'd3, 32'h2A);
        tick();
        wb(1'b0, 5'd0, 32'd0);
        req(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick(2);

        req(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
        tick();
        req(1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        req(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
        tick();
        req(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();

        op_ready = 1'b0;
        req(1'b1, 5'd1, 5'd6, 5'd0, 1'b0);
        tick();
        req(1'b1, 5'd2, 5'd7, 5'd9, 1'b0);
        tick(3);
        op_ready = 1'b1;
        tick();
        req(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick(2);

        req(1'b1, 5'd0, 5'd0, 5'd4, 1'b1);
        tick();
        req(1'b1, 5'd1, 5'd0, 5'd4, 1'b1);
        tick(2);
        wb(1'b1, 5'd4, 32'h44);
        tick();
        wb(1'b0, 5'd0, 32'd0);
        tick();
        req(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        wb(1'b1, 5'd4, 32'h45);
        tick();
        wb(1'b0, 5'd0, 32'd0);
        tick();

        op_ready = 1'b0;
        req(1'b1, 5'd0, 5'd0, 5'd5, 1'b1);
        tick();
        req(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        op_ready = 1'b1;
        req(1'b1, 5'd5, 5'd0, 5'd0, 1'b0);
        tick();
        req(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick(2);

        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            op_ready = ($urandom_range(0, 9) < 7);
            req($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            tick();
        end

        rst = 1'b0;
        op_ready = 1'b1;
        req(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        wb(1'b0, 5'd0, 32'd0);
        tick(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
